// File: rtl/dcache_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_buffer_pkg
// Purpose  : Shared types for the data-cache write-back buffer: the queued
//            eviction record and the read-miss FSM state encoding.
//            Optional macro WB_FORWARD_EN adds the FWD state.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_wb_buffer_pkg;

   localparam int WB_ADDRESS_BITS = 32;
   localparam int WB_BLOCK_DW     = 256;

   // One queued dirty eviction.  Field widths set the buffer's default
   // geometry; the top-level width parameters default to these values.
   typedef struct packed {
      logic [WB_ADDRESS_BITS-1:0] address;
      logic [WB_BLOCK_DW-1:0]     data;
   } WbEntry;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHECK     = 3'd1,
      DRAIN     = 3'd2,
      ISSUE     = 3'd3,
      WAIT_RESP = 3'd4
`ifdef WB_FORWARD_EN
      , FWD     = 3'd5
`endif
   } rd_state_e;

   // Number of byte-offset bits inside one cache block.
   function automatic int block_offset_bits(input int block_dw);
      return $clog2(block_dw / 8);
   endfunction

endpackage : dcache_wb_buffer_pkg
`default_nettype wire

// File: rtl/dcache_wb_buffer_addr_match.sv
`default_nettype none
// ============================================================================
// Module   : wb_addr_match
// Purpose  : DEPTH-way block-address comparator over the write-back entries.
//            Returns the per-entry match vector and, when WB_FORWARD_EN is
//            defined, the index of the most recently pushed matching entry.
// Revision : 1.0 - initial release
// ============================================================================
module wb_addr_match #(
   parameter int DEPTH = 4,
   parameter int BLK_W = 27,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic [BLK_W-1:0]            blk_addr_i,
   input  logic [DEPTH-1:0][BLK_W-1:0] entry_blk_i,
   input  logic [DEPTH-1:0]            entry_valid_i,
   output logic [DEPTH-1:0]            match_o,
   output logic                        any_match_o
`ifdef WB_FORWARD_EN
   ,
   input  logic [PTR_W-1:0]            head_i,
   output logic [PTR_W-1:0]            youngest_o
`endif
);

   for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign match_o[i] = entry_valid_i[i] && (entry_blk_i[i] == blk_addr_i);
   end

   assign any_match_o = |match_o;

`ifdef WB_FORWARD_EN
   // Walk from oldest (head) to youngest; the last match seen is the youngest.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx        = head_i;
      youngest_o = head_i;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + k[PTR_W-1:0];
         if (match_o[idx]) youngest_o = idx;
      end
   end
`endif

endmodule : wb_addr_match
`default_nettype wire

// File: rtl/dcache_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_buffer
// Purpose  : Write-back buffer between the data cache and memory.  Dirty
//            evictions queue in a circular FIFO and retire one per cycle;
//            read misses are checked against queued blocks so a read never
//            overtakes a pending write to the same block.
//            Macro WB_FORWARD_EN: serve a hitting miss from the buffer
//            instead of draining the matching writes first.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wb_buffer
   import dcache_wb_buffer_pkg::*;
#(
   parameter int ADDRESS_BITS    = WB_ADDRESS_BITS,
   parameter int DCACHE_BLOCK_DW = WB_BLOCK_DW,
   parameter int DEPTH           = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       evict_valid_i,
   output logic                       evict_ready_o,
   input  logic [ADDRESS_BITS-1:0]    evict_address_i,
   input  logic [DCACHE_BLOCK_DW-1:0] evict_data_i,
   input  logic                       miss_valid_i,
   output logic                       miss_ready_o,
   input  logic [ADDRESS_BITS-1:0]    miss_address_i,
   input  logic                       mem_ready_i,
   output logic                       mem_rd_valid_o,
   output logic [ADDRESS_BITS-1:0]    mem_rd_address_o,
   output logic                       mem_wr_valid_o,
   output logic [ADDRESS_BITS-1:0]    mem_wr_address_o,
   output logic [DCACHE_BLOCK_DW-1:0] mem_wr_data_o,
   input  logic                       mem_resp_valid_i,
   input  logic [ADDRESS_BITS-1:0]    mem_resp_address_i,
   input  logic [DCACHE_BLOCK_DW-1:0] mem_resp_data_i,
   output logic                       resp_valid_o,
   output logic [ADDRESS_BITS-1:0]    resp_address_o,
   output logic [DCACHE_BLOCK_DW-1:0] resp_data_o
);

   localparam int OFFSET_BITS = block_offset_bits(DCACHE_BLOCK_DW);
   localparam int BLK_W       = ADDRESS_BITS - OFFSET_BITS;
   localparam int PTR_W       = $clog2(DEPTH);
   localparam int CNT_W       = PTR_W + 1;

   WbEntry                     fifo_q [DEPTH];
   WbEntry                     fifo_d [DEPTH];
   logic [DEPTH-1:0]           valid_q, valid_d;
   logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]           count_q, count_d;
   rd_state_e                  state_q, state_d;
   logic [ADDRESS_BITS-1:0]    miss_addr_q, miss_addr_d;
   logic                       resp_valid_q, resp_valid_d;
   logic [ADDRESS_BITS-1:0]    resp_address_q, resp_address_d;
   logic [DCACHE_BLOCK_DW-1:0] resp_data_q, resp_data_d;

   logic                       w_full, w_push, w_pop, w_any_match;
   logic [DEPTH-1:0]           w_match;
   logic [DEPTH-1:0][BLK_W-1:0] w_entry_blk;
`ifdef WB_FORWARD_EN
   logic [PTR_W-1:0]           w_youngest;
`endif

   // A full buffer refuses pushes even while the head retires this cycle.
   assign w_full        = (count_q == CNT_W'(DEPTH));
   assign evict_ready_o = !w_full;
   assign w_push        = evict_valid_i && !w_full;

   // Reads win the memory port; both request strobes are masked during
   // reset so nothing stale reaches memory.
   assign mem_rd_valid_o   = !rst && (state_q == ISSUE) && mem_ready_i;
   assign mem_rd_address_o = miss_addr_q;
   assign mem_wr_valid_o   = !rst && valid_q[head_q] && mem_ready_i && (state_q != ISSUE);
   assign mem_wr_address_o = fifo_q[head_q].address;
   assign mem_wr_data_o    = fifo_q[head_q].data;
   assign w_pop            = mem_wr_valid_o;

   assign miss_ready_o   = (state_q == IDLE);
   assign resp_valid_o   = resp_valid_q;
   assign resp_address_o = resp_address_q;
   assign resp_data_o    = resp_data_q;

   // Block-address view of each queued entry for the comparator.
   always_comb begin
      w_entry_blk = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_entry_blk[i] = fifo_q[i].address[ADDRESS_BITS-1:OFFSET_BITS];
      end
   end

   wb_addr_match #(
      .DEPTH (DEPTH),
      .BLK_W (BLK_W)
   ) u_match (
      .blk_addr_i    (miss_addr_q[ADDRESS_BITS-1:OFFSET_BITS]),
      .entry_blk_i   (w_entry_blk),
      .entry_valid_i (valid_q),
      .match_o       (w_match),
      .any_match_o   (w_any_match)
`ifdef WB_FORWARD_EN
      ,
      .head_i        (head_q),
      .youngest_o    (w_youngest)
`endif
   );

   // FIFO next state: write at tail on push, retire head on pop.
   always_comb begin
      fifo_d  = fifo_q;
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (w_push) begin
         fifo_d[tail_q].address = evict_address_i;
         fifo_d[tail_q].data    = evict_data_i;
         valid_d[tail_q]        = 1'b1;
         tail_d                 = tail_q + PTR_W'(1);
      end
   end

   // Read-miss FSM: hazard check, optional drain/forward, memory read.
   always_comb begin
      state_d        = state_q;
      miss_addr_d    = miss_addr_q;
      resp_valid_d   = 1'b0;
      resp_address_d = resp_address_q;
      resp_data_d    = resp_data_q;
      case (state_q)
         IDLE: begin
            if (miss_valid_i) begin
               miss_addr_d = miss_address_i;
               state_d     = CHECK;
            end
         end
         CHECK: begin
`ifdef WB_FORWARD_EN
            state_d = w_any_match ? FWD : ISSUE;
`else
            state_d = w_any_match ? DRAIN : ISSUE;
`endif
         end
         DRAIN: begin
            if (!w_any_match) state_d = ISSUE;
         end
         ISSUE: begin
            if (mem_ready_i) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (mem_resp_valid_i) begin
               resp_valid_d   = 1'b1;
               resp_address_d = mem_resp_address_i;
               resp_data_d    = mem_resp_data_i;
               state_d        = IDLE;
            end
         end
`ifdef WB_FORWARD_EN
         // If every match retired to memory meanwhile, memory is now
         // coherent and a normal read is issued instead.
         FWD: begin
            if (w_any_match) begin
               resp_valid_d   = 1'b1;
               resp_address_d = miss_addr_q;
               resp_data_d    = fifo_q[w_youngest].data;
               state_d        = IDLE;
            end else begin
               state_d = ISSUE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Control and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         state_q        <= IDLE;
         miss_addr_q    <= '0;
         resp_valid_q   <= 1'b0;
         resp_address_q <= '0;
         resp_data_q    <= '0;
      end else begin
         valid_q        <= valid_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         state_q        <= state_d;
         miss_addr_q    <= miss_addr_d;
         resp_valid_q   <= resp_valid_d;
         resp_address_q <= resp_address_d;
         resp_data_q    <= resp_data_d;
      end
   end

   // Entry payload storage; validity is tracked by valid_q, so no reset.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule : dcache_wb_buffer
`default_nettype wire
